// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding
// and default configuration constants.
package bus_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SEL_BITS = 2;
  localparam int unsigned TIMEOUT  = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    WAIT_SLAVE = 3'd2,
    CONNECT    = 3'd3,
    RELEASE    = 3'd4
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first set request at or after ptr,
// wrapping modulo N.
module rr_picker #(
  parameter int unsigned N = 2,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int unsigned cand;
    cand = 0;
    idx  = '0;
    any  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter connecting NUM_MASTERS serial masters to NUM_SLAVES
// slaves; the owner shifts a slave select in, then gets a direct connection.
module bus_arbiter_rr
  import bus_pkg::state_t, bus_pkg::STATE_W, bus_pkg::IDLE, bus_pkg::SELECT,
         bus_pkg::WAIT_SLAVE, bus_pkg::CONNECT, bus_pkg::RELEASE;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned SEL_BITS    = bus_pkg::SEL_BITS,
  parameter int unsigned TIMEOUT     = bus_pkg::TIMEOUT,
  localparam int unsigned OW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0] m_addr_valid,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_valid_in,
  output logic [NUM_MASTERS-1:0] m_error,
  output logic                   m_data_out,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  input  logic [NUM_SLAVES-1:0]  s_data_in,
  input  logic [NUM_SLAVES-1:0]  s_valid_out,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  output logic [NUM_SLAVES-1:0]  s_bus_ready,
  output logic [STATE_W-1:0]     state,
  output logic [OW-1:0]          owner
);

  localparam int unsigned BW = $clog2(SEL_BITS + 1);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t                  state_r, state_nx;
  logic [OW-1:0]           owner_r, rr_ptr, pick_idx;
  logic                    pick_any;
  logic [SEL_BITS-1:0]     sel;
  logic [BW-1:0]           bit_cnt;
  logic [CW-1:0]           wait_cnt;
  logic [NUM_MASTERS-1:0]  own_hit;
  logic [NUM_SLAVES-1:0]   sel_hit;
  logic own_req, own_addr, own_addr_valid, own_data, own_valid, own_we;
  logic sel_ok, sel_ready, timed_out, last_bit;

  rr_picker #(.N(NUM_MASTERS)) u_pick (
    .req (m_req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One-hot decodes avoid indexing with out-of-range sel values.
  always_comb begin
    own_hit = '0;
    sel_hit = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) own_hit[m] = (owner_r == OW'(m));
    for (int unsigned s = 0; s < NUM_SLAVES; s++)  sel_hit[s] = (sel == SEL_BITS'(s));
  end

  assign own_req        = |(own_hit & m_req);
  assign own_addr       = |(own_hit & m_addr);
  assign own_addr_valid = |(own_hit & m_addr_valid);
  assign own_data       = |(own_hit & m_data);
  assign own_valid      = |(own_hit & m_valid);
  assign own_we         = |(own_hit & m_write_en);
  assign sel_ok         = |sel_hit;
  assign sel_ready      = |(sel_hit & s_ready);
  assign timed_out      = (wait_cnt == CW'(TIMEOUT));
  assign last_bit       = (bit_cnt == BW'(SEL_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:       if (pick_any) state_nx = SELECT;
      SELECT: begin
        if (!own_req)                       state_nx = RELEASE;
        else if (own_addr_valid && last_bit) state_nx = WAIT_SLAVE;
      end
      WAIT_SLAVE: begin
        if (!own_req || !sel_ok) state_nx = RELEASE;
        else if (sel_ready)      state_nx = CONNECT;
        else if (timed_out)      state_nx = RELEASE;
      end
      CONNECT:    if (!own_req) state_nx = RELEASE;
      RELEASE:    state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r  <= '0;
      rr_ptr   <= '0;
      sel      <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state_r != WAIT_SLAVE)   wait_cnt <= '0;
      else if (!timed_out)         wait_cnt <= wait_cnt + 1'b1;
      case (state_r)
        IDLE: if (pick_any) begin
          owner_r <= pick_idx;
          sel     <= '0;
          bit_cnt <= '0;
        end
        SELECT: if (own_req && own_addr_valid) begin
          sel     <= (sel << 1) | SEL_BITS'(own_addr);
          bit_cnt <= bit_cnt + 1'b1;
        end
        RELEASE: rr_ptr <= (owner_r == OW'(NUM_MASTERS - 1)) ? '0 : owner_r + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_grant     = '0;
    m_valid_in  = '0;
    m_error     = '0;
    m_data_out  = 1'b0;
    s_address   = '0;
    s_data      = '0;
    s_valid     = '0;
    s_write_en  = '0;
    s_bus_ready = '0;
    state       = state_r;
    owner       = owner_r;
    case (state_r)
      SELECT:     m_grant = own_hit;
      WAIT_SLAVE: if (!sel_ok || (!sel_ready && timed_out)) m_error = own_hit;
      CONNECT: begin
        m_grant     = own_hit;
        s_bus_ready = sel_hit;
        s_address   = sel_hit & {NUM_SLAVES{own_addr}};
        s_data      = sel_hit & {NUM_SLAVES{own_data}};
        s_valid     = sel_hit & {NUM_SLAVES{own_valid}};
        s_write_en  = sel_hit & {NUM_SLAVES{own_we}};
        m_data_out  = |(sel_hit & s_data_in);
        m_valid_in  = own_hit & {NUM_MASTERS{|(sel_hit & s_valid_out)}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed testbench for bus_arbiter_rr with 2 masters, 3 slaves, 2 select
// bits and a 64-cycle slave timeout.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] m_req, m_addr, m_addr_valid, m_data, m_valid, m_write_en;
  logic [1:0] m_grant, m_valid_in, m_error;
  logic       m_data_out;
  logic [2:0] s_ready, s_data_in, s_valid_out;
  logic [2:0] s_address, s_data, s_valid, s_write_en, s_bus_ready;
  logic [2:0] state;
  logic [0:0] owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .NUM_MASTERS(2),
    .NUM_SLAVES (3),
    .SEL_BITS   (2),
    .TIMEOUT    (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_addr_valid(m_addr_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_write_en  (m_write_en),
    .m_grant     (m_grant),
    .m_valid_in  (m_valid_in),
    .m_error     (m_error),
    .m_data_out  (m_data_out),
    .s_ready     (s_ready),
    .s_data_in   (s_data_in),
    .s_valid_out (s_valid_out),
    .s_address   (s_address),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_write_en  (s_write_en),
    .s_bus_ready (s_bus_ready),
    .state       (state),
    .owner       (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_req = '0; m_addr = '0; m_addr_valid = '0; m_data = '0; m_valid = '0;
    m_write_en = '0; s_ready = '0; s_data_in = '0; s_valid_out = '0;
  endtask

  // Shifts a 2-bit select MSB first from master m; leaves the FSM in WAIT_SLAVE.
  task automatic shift_sel(input int m, input logic [1:0] v);
    for (int i = 1; i >= 0; i--) begin
      m_addr_valid[m] = 1'b1;
      m_addr[m]       = v[i];
      tick();
    end
    m_addr_valid[m] = 1'b0;
    m_addr[m]       = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (3) tick();
    m_req = 2'b11;
    tick();
    checks++; if (state !== 3'd0)       begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (m_grant !== 2'b00)    begin errors++; $display("FAIL reset_grant: got %b expected 00", m_grant); end
    checks++; if (owner !== 1'b0)       begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (s_bus_ready !== 3'b0) begin errors++; $display("FAIL reset_bus_ready: got %b expected 000", s_bus_ready); end
    clear_inputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_transfer();
    m_req = 2'b01;
    #1;
    checks++; if (m_grant !== 2'b00) begin errors++; $display("FAIL single_idle_grant: got %b expected 00", m_grant); end
    tick();
    checks++; if (state !== 3'd1)    begin errors++; $display("FAIL single_select_state: got %0d expected 1", state); end
    checks++; if (m_grant !== 2'b01) begin errors++; $display("FAIL single_grant_latency: got %b expected 01", m_grant); end
    s_ready = 3'b010;
    shift_sel(0, 2'b01);
    checks++; if (state !== 3'd2)    begin errors++; $display("FAIL single_wait_state: got %0d expected 2", state); end
    checks++; if (m_grant !== 2'b00) begin errors++; $display("FAIL single_wait_grant: got %b expected 00", m_grant); end
    tick();
    checks++; if (state !== 3'd3)          begin errors++; $display("FAIL single_connect_state: got %0d expected 3", state); end
    checks++; if (m_grant !== 2'b01)       begin errors++; $display("FAIL single_connect_grant: got %b expected 01", m_grant); end
    checks++; if (s_bus_ready !== 3'b010)  begin errors++; $display("FAIL single_bus_ready: got %b expected 010", s_bus_ready); end
    m_data = 2'b11; m_valid = 2'b01; m_write_en = 2'b01; m_addr = 2'b01;
    #1;
    checks++; if (s_data !== 3'b010)     begin errors++; $display("FAIL single_s_data_hi: got %b expected 010", s_data); end
    checks++; if (s_valid !== 3'b010)    begin errors++; $display("FAIL single_s_valid: got %b expected 010", s_valid); end
    checks++; if (s_write_en !== 3'b010) begin errors++; $display("FAIL single_s_write_en: got %b expected 010", s_write_en); end
    checks++; if (s_address !== 3'b010)  begin errors++; $display("FAIL single_s_address: got %b expected 010", s_address); end
    m_data = 2'b10;
    #1;
    checks++; if (s_data !== 3'b000)     begin errors++; $display("FAIL single_s_data_lo: got %b expected 000", s_data); end
    s_valid_out = 3'b010; s_data_in = 3'b010;
    #1;
    checks++; if (m_valid_in !== 2'b01)  begin errors++; $display("FAIL read_valid_in: got %b expected 01", m_valid_in); end
    checks++; if (m_data_out !== 1'b1)   begin errors++; $display("FAIL read_data_out: got %b expected 1", m_data_out); end
    s_valid_out = 3'b001; s_data_in = 3'b001;
    #1;
    checks++; if (m_valid_in !== 2'b00)  begin errors++; $display("FAIL read_other_slave_valid: got %b expected 00", m_valid_in); end
    checks++; if (m_data_out !== 1'b0)   begin errors++; $display("FAIL read_other_slave_data: got %b expected 0", m_data_out); end
    clear_inputs();
    tick();
    checks++; if (state !== 3'd4)    begin errors++; $display("FAIL single_release_state: got %0d expected 4", state); end
    checks++; if (m_grant !== 2'b00) begin errors++; $display("FAIL single_release_grant: got %b expected 00", m_grant); end
    tick();
    checks++; if (state !== 3'd0)    begin errors++; $display("FAIL single_back_idle: got %0d expected 0", state); end
  endtask

  task automatic test_async_reset();
    m_req = 2'b01;
    tick();
    s_ready = 3'b010;
    shift_sel(0, 2'b01);
    tick();
    m_data = 2'b01; m_valid = 2'b01; s_valid_out = 3'b010; s_data_in = 3'b010;
    #1;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL areset_pre_connect: got %0d expected 3", state); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0)       begin errors++; $display("FAIL areset_state: got %0d expected 0", state); end
    checks++; if (m_grant !== 2'b00)    begin errors++; $display("FAIL areset_grant: got %b expected 00", m_grant); end
    checks++; if (s_bus_ready !== 3'b0) begin errors++; $display("FAIL areset_bus_ready: got %b expected 000", s_bus_ready); end
    checks++; if (s_data !== 3'b0)      begin errors++; $display("FAIL areset_s_data: got %b expected 000", s_data); end
    checks++; if (m_valid_in !== 2'b00) begin errors++; $display("FAIL areset_valid_in: got %b expected 00", m_valid_in); end
    checks++; if (m_data_out !== 1'b0)  begin errors++; $display("FAIL areset_data_out: got %b expected 0", m_data_out); end
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL areset_resume_idle: got %0d expected 0", state); end
  endtask

  task automatic test_back_to_back();
    m_req = 2'b11;
    tick();
    checks++; if (owner !== 1'b0)    begin errors++; $display("FAIL rr_first_owner: got %0d expected 0", owner); end
    checks++; if (m_grant !== 2'b01) begin errors++; $display("FAIL rr_first_grant: got %b expected 01", m_grant); end
    s_ready = 3'b010;
    shift_sel(0, 2'b01);
    tick();
    checks++; if (state !== 3'd3)    begin errors++; $display("FAIL rr_connect: got %0d expected 3", state); end
    m_req = 2'b10;
    tick();
    checks++; if (state !== 3'd4)    begin errors++; $display("FAIL rr_gap_release: got %0d expected 4", state); end
    checks++; if (m_grant !== 2'b00) begin errors++; $display("FAIL rr_gap_grant1: got %b expected 00", m_grant); end
    tick();
    checks++; if (state !== 3'd0)    begin errors++; $display("FAIL rr_gap_idle: got %0d expected 0", state); end
    checks++; if (m_grant !== 2'b00) begin errors++; $display("FAIL rr_gap_grant2: got %b expected 00", m_grant); end
    tick();
    checks++; if (owner !== 1'b1)    begin errors++; $display("FAIL rr_second_owner: got %0d expected 1", owner); end
    checks++; if (m_grant !== 2'b10) begin errors++; $display("FAIL rr_second_grant: got %b expected 10", m_grant); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    m_req = 2'b01;
    s_ready = 3'b010;
    tick();
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL to_owner: got %0d expected 0", owner); end
    shift_sel(0, 2'b10);
    for (int c = 0; c < 64; c++) begin
      if (state !== 3'd2 || m_error !== 2'b00 || s_bus_ready !== 3'b000) bad++;
      tick();
    end
    checks++; if (bad !== 0)             begin errors++; $display("FAIL to_early_cycles: got %0d bad cycles expected 0", bad); end
    checks++; if (state !== 3'd2)        begin errors++; $display("FAIL to_last_wait: got %0d expected 2", state); end
    checks++; if (m_error !== 2'b01)     begin errors++; $display("FAIL to_error_pulse: got %b expected 01", m_error); end
    tick();
    checks++; if (state !== 3'd4)        begin errors++; $display("FAIL to_release: got %0d expected 4", state); end
    checks++; if (m_error !== 2'b00)     begin errors++; $display("FAIL to_error_one_cycle: got %b expected 00", m_error); end
    clear_inputs();
    tick();
    checks++; if (state !== 3'd0)        begin errors++; $display("FAIL to_idle: got %0d expected 0", state); end
  endtask

  task automatic test_bad_select();
    m_req = 2'b10;
    s_ready = 3'b111;
    tick();
    checks++; if (owner !== 1'b1)    begin errors++; $display("FAIL badsel_owner: got %0d expected 1", owner); end
    checks++; if (m_grant !== 2'b10) begin errors++; $display("FAIL badsel_grant: got %b expected 10", m_grant); end
    shift_sel(1, 2'b11);
    checks++; if (m_error !== 2'b10)     begin errors++; $display("FAIL badsel_error: got %b expected 10", m_error); end
    checks++; if (s_bus_ready !== 3'b0)  begin errors++; $display("FAIL badsel_bus_ready_wait: got %b expected 000", s_bus_ready); end
    tick();
    checks++; if (state !== 3'd4)        begin errors++; $display("FAIL badsel_release: got %0d expected 4", state); end
    checks++; if (s_bus_ready !== 3'b0)  begin errors++; $display("FAIL badsel_bus_ready_rel: got %b expected 000", s_bus_ready); end
    clear_inputs();
    tick();
  endtask

  task automatic test_abandon();
    m_req = 2'b01;
    tick();
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL abandon_owner: got %0d expected 0", owner); end
    m_req = 2'b00;
    tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL abandon_release: got %0d expected 4", state); end
    tick();
    m_req = 2'b11;
    tick();
    checks++; if (owner !== 1'b1)    begin errors++; $display("FAIL abandon_next_owner: got %0d expected 1", owner); end
    checks++; if (m_grant !== 2'b10) begin errors++; $display("FAIL abandon_next_grant: got %b expected 10", m_grant); end
    clear_inputs();
    tick();
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL abandon_final_idle: got %0d expected 0", state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_transfer();
    test_async_reset();
    test_back_to_back();
    test_timeout();
    test_bad_select();
    test_abandon();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of master ports (2..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 3: number of slave ports (2..4).
REQ-003 SHALL have parameter SEL_BITS, default 2: leading serial address bits that select the slave; must satisfy 2**SEL_BITS >= NUM_SLAVES.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for the selected slave's ready.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have ports m_req, m_addr, m_addr_valid, m_data, m_valid, m_write_en, each input, NUM_MASTERS: per-master request, serial address, address qualifier, serial data, data qualifier and write enable.
REQ-008 SHALL have ports m_grant, m_valid_in and m_error, each output, NUM_MASTERS: bus available, read-data qualifier and one-cycle error pulse.
REQ-009 SHALL have port m_data_out, output, 1: serial read data shared by all masters, qualified by m_valid_in.
REQ-010 SHALL have ports s_ready, s_data_in and s_valid_out, each input, NUM_SLAVES: slave ready, serial read data and read-data qualifier.
REQ-011 SHALL have ports s_address, s_data, s_valid, s_write_en and s_bus_ready, each output, NUM_SLAVES: forwarded master signals plus bus-ready to the slave.
REQ-012 SHALL have port state, output, 3: current FSM state encoding.
REQ-013 SHALL have port owner, output, clog2(NUM_MASTERS): index of the current or most recent bus owner.

Function
REQ-014 SHALL implement states IDLE=0, SELECT=1, WAIT_SLAVE=2, CONNECT=3, RELEASE=4.
REQ-015 IDLE: with any m_req bit set, SHALL latch as owner the first requester at or after rr_ptr (wrapping modulo NUM_MASTERS) and go to SELECT next cycle.
REQ-016 SELECT: m_grant[owner]=1; each cycle with m_addr_valid[owner]=1 SHALL shift m_addr[owner] into sel, MSB first; after SEL_BITS bits SHALL go to WAIT_SLAVE.
REQ-017 WAIT_SLAVE: m_grant[owner]=0 (the master pauses shifting); an out-of-range sel (>= NUM_SLAVES) SHALL pulse m_error[owner] and go to RELEASE.
REQ-018 WAIT_SLAVE: s_ready[sel]=1 SHALL go to CONNECT; otherwise the wait counter increments and, on reaching TIMEOUT, SHALL pulse m_error[owner] and go to RELEASE.
REQ-019 CONNECT: m_grant[owner]=1 and s_bus_ready[sel]=1; s_address, s_data, s_valid and s_write_en of slave sel SHALL combinationally follow master owner; m_data_out=s_data_in[sel]; m_valid_in[owner]=s_valid_out[sel].
REQ-020 All non-selected slave and non-owner master outputs SHALL be 0 in every state.
REQ-021 m_req[owner] falling in SELECT, WAIT_SLAVE or CONNECT SHALL go to RELEASE next cycle; the transfer is abandoned.
REQ-022 RELEASE: all grants 0 for exactly one cycle; rr_ptr <= (owner+1) mod NUM_MASTERS; then IDLE.
REQ-023 Request to grant latency SHALL be 1 cycle from IDLE; the back-to-back handover gap SHALL be 2 cycles (RELEASE, IDLE).
REQ-024 With simultaneous requests, the round-robin pointer SHALL decide; no master waits more than NUM_MASTERS-1 tenures.
REQ-025 The wait counter SHALL be clog2(TIMEOUT+1) bits wide, cleared on entry to WAIT_SLAVE, and non-wrapping.

Reset
REQ-026 While reset=0: state=IDLE, rr_ptr=0, owner=0, sel=0, counter=0, and all outputs 0, regardless of the current state.
REQ-027 Reset deassertion mid-transfer SHALL resume from IDLE; no partial grant is retained.

Structure
REQ-028 A shared package bus_pkg SHALL hold the state encoding type and the constants SEL_BITS, TIMEOUT and the state width, for use by the arbiter, masters and the top level.
REQ-029 The round-robin pick SHALL be a sub-module rr_picker (inputs req and ptr; outputs idx and any).

Verification
REQ-030 M0 requests, shifts sel=01, s_ready[1]=1 -> m_grant[0] one cycle after m_req; CONNECT; s_bus_ready[1]=1; M0 serial data appears on s_data[1].
REQ-031 M0 and M1 request together with rr_ptr=0 -> M0 owns; after M0 drops its request, M1 is granted 2 cycles later with owner=1.
REQ-032 sel=10 with s_ready[2]=0 for 64 cycles -> m_error[0] pulses for 1 cycle at cycle 64, then RELEASE, then IDLE.
REQ-033 sel=11 with NUM_SLAVES=3 -> m_error pulse, no s_bus_ready asserted.
REQ-034 In CONNECT, s_valid_out[1]=1 with s_data_in[1]=1 -> m_valid_in[owner]=1 and m_data_out=1 in the same cycle; other m_valid_in bits stay 0.
REQ-035 reset=0 asserted during CONNECT -> all outputs 0 immediately (asynchronous); after release, state=0 and rr_ptr=0.
